// File: rtl/qmem_pkg.sv
// Shared widths and FSM encoding for the qmem RAM responder.
// Imported by the responder and its storage array.
package qmem_pkg;

  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int ADDR_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/qmem_ram_array.sv
// Single-port 64-bit RAM with byte-lane writes and a registered read port.
// Contents are never reset; only the read register is.
module qmem_ram_array
  import qmem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Out-of-range reads load zero instead of an aliased word
  always_ff @(posedge clk) begin
    if (rst || rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/qmem_ram_responder.sv
// Memory-bus responder: wait-state FSM, request capture and range check
// in front of a byte-lane RAM array.
module qmem_ram_responder
  import qmem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stb,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [BE_W-1:0]   mem_byte_en,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              addr_err
);

  localparam int         IW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] cap_addr;
  logic [BE_W-1:0]   cap_be;
  logic              capture;
  logic              ack;
  logic              same_req;
  logic              in_range;
  logic              is_read;

  assign same_req = (mem_addr == cap_addr)
                 && (mem_byte_en == cap_be);
  assign in_range = {3'b000, mem_addr[ADDR_W-1:3]}
                  < 32'(DEPTH);
  assign is_read  = (mem_byte_en == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    ack     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_stb) begin
          if (WS == 4'd0) begin
            ack = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 4'd1;
            capture = 1'b1;
          end
        end
      end
      S_WAIT: begin
        unique case (1'b1)
          !mem_stb: begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
          end
          mem_stb && !same_req: begin
            cnt_n   = 4'd1;
            capture = 1'b1;
          end
          mem_stb && same_req && (cnt == WS): begin
            ack     = 1'b1;
            state_n = S_IDLE;
            cnt_n   = 4'd0;
          end
          default: begin
            cnt_n = cnt + 4'd1;
          end
        endcase
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  assign mem_ack = ack && !rst;
  assign busy    = (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      addr_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (mem_ack && !in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cap_addr <= mem_addr;
      cap_be   <= mem_byte_en;
    end
  end

  qmem_ram_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (mem_ack && is_read && in_range),
    .rd_clr (mem_ack && is_read && !in_range),
    .wr_be  ((mem_ack && in_range) ? mem_byte_en : '0),
    .idx    (mem_addr[IW+2:3]),
    .wdata  (mem_wdata),
    .rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_qmem_ram_responder.sv
// Bench for qmem_ram_responder: three instances (0, 2, 3 wait states)
// checked against a word-array reference model.
module tb_qmem_ram_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst   [N];
  logic        stb   [N];
  logic [31:0] addr  [N];
  logic [7:0]  be    [N];
  logic [63:0] wd    [N];
  logic        ack   [N];
  logic [63:0] rdata [N];
  logic        busy  [N];
  logic        err   [N];

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] mdl     [N][64];
  logic [63:0] last_rd [N];
  logic        merr    [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    qmem_ram_responder #(
      .DEPTH       (4096),
      .WAIT_STATES ((g == 0) ? 0 : g + 1)
    ) dut (
      .clk         (clk),
      .rst         (rst[g]),
      .mem_stb     (stb[g]),
      .mem_addr    (addr[g]),
      .mem_byte_en (be[g]),
      .mem_wdata   (wd[g]),
      .mem_ack     (ack[g]),
      .mem_rdata   (rdata[g]),
      .busy        (busy[g]),
      .addr_err    (err[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  // Reference: word array plus last read value and sticky error
  function automatic logic [63:0] ref_access(
    input int k, input logic [31:0] a,
    input logic [7:0] b, input logic [63:0] d);
    bit in_r;
    int w;
    in_r = (a >> 3) < 32'd4096;
    w    = int'(a[8:3]);
    if (!in_r) merr[k] = 1'b1;
    if (b == 8'h00) begin
      last_rd[k] = in_r ? mdl[k][w] : 64'h0;
    end else if (in_r) begin
      for (int i = 0; i < 8; i++)
        if (b[i]) mdl[k][w][8*i +: 8] = d[8*i +: 8];
    end
    return last_rd[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    stb[k] = 1'b0;
    be[k]  = 8'h00;
    step();
  endtask

  // Drives one request and leaves stb high; returns cycles to ack
  task automatic do_access(
    input int k, input logic [31:0] a,
    input logic [7:0] b, input logic [63:0] d,
    output int lat, output int busy_bad,
    output logic [63:0] rd);
    stb[k]   = 1'b1;
    addr[k]  = a;
    be[k]    = b;
    wd[k]    = d;
    lat      = 0;
    busy_bad = 0;
    forever begin
      @(negedge clk);
      if (lat > 0 && busy[k] !== 1'b1) busy_bad++;
      if (ack[k] === 1'b1) break;
      lat++;
      if (lat > 40) break;
      @(posedge clk);
      #1;
    end
    step();
    rd = rdata[k];
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      rst[k]  = 1'b1;
      stb[k]  = 1'b1;
      addr[k] = 32'h0;
      be[k]   = 8'h00;
      wd[k]   = 64'h0;
      last_rd[k] = 64'h0;
      merr[k]    = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        n_chk++;
        if (ack[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_ack k=%0d got %b exp 0", k, ack[k]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0;
      stb[k] = 1'b0;
      n_chk++;
      if (rdata[k] !== 64'h0 || err[k] !== 1'b0
          || busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d rd=%h err=%b busy=%b exp 0/0/0",
                 k, rdata[k], err[k], busy[k]);
      end
    end
  endtask

  task automatic test_preload();
    int lat, bb;
    logic [63:0] rd, d, exp;
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < 64; w++) begin
        d = {$urandom, $urandom};
        do_access(k, 32'(w * 8), 8'hFF, d, lat, bb, rd);
        exp = ref_access(k, 32'(w * 8), 8'hFF, d);
        n_chk++;
        if (lat != ws(k) || bb != 0 || rd !== exp) begin
          n_fail++;
          $display("FAIL preload k=%0d w=%0d lat=%0d bb=%0d rd=%h exp lat=%0d rd=%h",
                   k, w, lat, bb, rd, ws(k), exp);
        end
      end
      idle(k);
    end
  endtask

  task automatic test_basic_rw();
    int lat, bb;
    logic [63:0] rd;
    idle(0);
    do_access(0, 32'h10, 8'hFF, 64'h0123456789ABCDEF, lat, bb, rd);
    void'(ref_access(0, 32'h10, 8'hFF, 64'h0123456789ABCDEF));
    do_access(0, 32'h10, 8'h00, 64'h0, lat, bb, rd);
    void'(ref_access(0, 32'h10, 8'h00, 64'h0));
    n_chk++;
    if (lat != 0 || rd !== 64'h0123456789ABCDEF) begin
      n_fail++;
      $display("FAIL basic_rw lat=%0d rd=%h exp lat=0 rd=0123456789abcdef",
               lat, rd);
    end
    idle(0);
  endtask

  task automatic test_byte_lanes();
    int lat, bb;
    logic [63:0] rd;
    do_access(0, 32'h20, 8'hFF, '1, lat, bb, rd);
    void'(ref_access(0, 32'h20, 8'hFF, '1));
    do_access(0, 32'h20, 8'hF0, 64'h0, lat, bb, rd);
    void'(ref_access(0, 32'h20, 8'hF0, 64'h0));
    do_access(0, 32'h20, 8'h00, 64'h0, lat, bb, rd);
    void'(ref_access(0, 32'h20, 8'h00, 64'h0));
    n_chk++;
    if (rd !== 64'h00000000FFFFFFFF) begin
      n_fail++;
      $display("FAIL byte_lanes rd=%h exp 00000000ffffffff", rd);
    end
    idle(0);
  endtask

  task automatic test_wait_states();
    int lat, bb;
    logic [63:0] rd, exp;
    idle(2);
    do_access(2, 32'h40, 8'h00, 64'h0, lat, bb, rd);
    exp = ref_access(2, 32'h40, 8'h00, 64'h0);
    n_chk++;
    if (lat != 3 || bb != 0 || rd !== exp) begin
      n_fail++;
      $display("FAIL ws3_read lat=%0d bb=%0d rd=%h exp lat=3 rd=%h",
               lat, bb, rd, exp);
    end
    idle(2);
    stb[2]  = 1'b1;
    addr[2] = 32'h40;
    be[2]   = 8'h00;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (ack[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL ws3_pre_switch ack=%b exp 0", ack[2]);
      end
      step();
    end
    do_access(2, 32'h48, 8'h00, 64'h0, lat, bb, rd);
    exp = ref_access(2, 32'h48, 8'h00, 64'h0);
    n_chk++;
    if (lat != 3 || bb != 0 || rd !== exp) begin
      n_fail++;
      $display("FAIL ws3_switch lat=%0d bb=%0d rd=%h exp lat=3 rd=%h",
               lat, bb, rd, exp);
    end
    idle(2);
  endtask

  task automatic test_abort();
    int lat, bb;
    logic [63:0] rd, exp;
    idle(1);
    stb[1]  = 1'b1;
    addr[1] = 32'h30;
    be[1]   = 8'hFF;
    wd[1]   = ~mdl[1][6];
    @(negedge clk);
    n_chk++;
    if (ack[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_first ack=%b exp 0", ack[1]);
    end
    step();
    stb[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ack[1] !== 1'b0 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_drop ack=%b busy=%b exp 0/1", ack[1], busy[1]);
    end
    step();
    n_chk++;
    if (busy[1] !== 1'b0 || rdata[1] !== last_rd[1]) begin
      n_fail++;
      $display("FAIL abort_after busy=%b rd=%h exp 0 rd=%h",
               busy[1], rdata[1], last_rd[1]);
    end
    do_access(1, 32'h30, 8'h00, 64'h0, lat, bb, rd);
    exp = ref_access(1, 32'h30, 8'h00, 64'h0);
    n_chk++;
    if (lat != 2 || rd !== exp) begin
      n_fail++;
      $display("FAIL abort_readback lat=%0d rd=%h exp lat=2 rd=%h",
               lat, rd, exp);
    end
    idle(1);
  endtask

  task automatic test_out_of_range();
    int lat, bb;
    logic [63:0] rd, exp;
    idle(0);
    do_access(0, 32'h0000_8000, 8'h00, 64'h0, lat, bb, rd);
    void'(ref_access(0, 32'h0000_8000, 8'h00, 64'h0));
    n_chk++;
    if (lat != 0 || rd !== 64'h0 || err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_read lat=%0d rd=%h err=%b exp 0/0/1",
               lat, rd, err[0]);
    end
    do_access(0, 32'h0000_8000, 8'hFF, ~mdl[0][0], lat, bb, rd);
    void'(ref_access(0, 32'h0000_8000, 8'hFF, ~mdl[0][0]));
    do_access(0, 32'h0, 8'h00, 64'h0, lat, bb, rd);
    exp = ref_access(0, 32'h0, 8'h00, 64'h0);
    n_chk++;
    if (rd !== exp || err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_write_drop rd=%h err=%b exp rd=%h err=1",
               rd, err[0], exp);
    end
    stb[0] = 1'b0;
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    last_rd[0] = 64'h0;
    merr[0]    = 1'b0;
    n_chk++;
    if (err[0] !== 1'b0 || rdata[0] !== 64'h0) begin
      n_fail++;
      $display("FAIL oob_reset err=%b rd=%h exp 0/0", err[0], rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    logic [63:0] rd, d, prev;
    idle(0);
    d    = {$urandom, $urandom};
    prev = last_rd[0];
    do_access(0, 32'h50, 8'hFF, d, lat, bb, rd);
    void'(ref_access(0, 32'h50, 8'hFF, d));
    n_chk++;
    if (lat != 0 || rd !== prev) begin
      n_fail++;
      $display("FAIL b2b_write lat=%0d rd=%h exp lat=0 rd=%h", lat, rd, prev);
    end
    do_access(0, 32'h50, 8'h00, 64'h0, lat, bb, rd);
    void'(ref_access(0, 32'h50, 8'h00, 64'h0));
    n_chk++;
    if (lat != 0 || rd !== d) begin
      n_fail++;
      $display("FAIL b2b_read lat=%0d rd=%h exp lat=0 rd=%h", lat, rd, d);
    end
    idle(0);
  endtask

  task automatic test_reset_in_wait();
    int lat, bb;
    logic [63:0] rd, exp;
    idle(2);
    stb[2]  = 1'b1;
    addr[2] = 32'h60;
    be[2]   = 8'hFF;
    wd[2]   = ~mdl[2][12];
    repeat (3) step();
    rst[2] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ack[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_ack ack=%b exp 0", ack[2]);
    end
    step();
    rst[2] = 1'b0;
    stb[2] = 1'b0;
    last_rd[2] = 64'h0;
    merr[2]    = 1'b0;
    n_chk++;
    if (busy[2] !== 1'b0 || rdata[2] !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_wait_state busy=%b rd=%h exp 0/0", busy[2], rdata[2]);
    end
    step();
    do_access(2, 32'h60, 8'h00, 64'h0, lat, bb, rd);
    exp = ref_access(2, 32'h60, 8'h00, 64'h0);
    n_chk++;
    if (lat != 3 || rd !== exp) begin
      n_fail++;
      $display("FAIL rst_wait_readback lat=%0d rd=%h exp lat=3 rd=%h",
               lat, rd, exp);
    end
    idle(2);
  endtask

  task automatic test_random();
    int lat, bb, sel;
    logic [31:0] a;
    logic [7:0]  b;
    logic [63:0] d, rd, exp;
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 150; n++) begin
        sel = int'($urandom_range(0, 9));
        a   = {23'd0, 6'($urandom_range(0, 63)), 3'($urandom)};
        b   = (sel < 4) ? 8'h00 : 8'($urandom);
        d   = {$urandom, $urandom};
        if (sel == 9) a = 32'h0000_8000 + ($urandom & 32'h0FFF_FFFF);
        do_access(k, a, b, d, lat, bb, rd);
        exp = ref_access(k, a, b, d);
        n_chk++;
        if (lat != ws(k) || bb != 0 || rd !== exp || err[k] !== merr[k]) begin
          n_fail++;
          $display("FAIL random k=%0d a=%h be=%h lat=%0d bb=%0d rd=%h err=%b exp lat=%0d rd=%h err=%b",
                   k, a, b, lat, bb, rd, err[k], ws(k), exp, merr[k]);
        end
        if ($urandom_range(0, 3) == 0) idle(k);
      end
      idle(k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_preload();
    test_basic_rw();
    test_byte_lanes();
    test_wait_states();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
